// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage controller.
// Holds the MEM-stage FSM state encodings, the bit positions of the EX/MEM
// MEM and WB control bundles, and the WB bubble value. Imported by every
// file of the MEM stage so that encodings and field positions live in one place.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // EX_MEM_MEM_signals = {MemWriteData, MemEnable, MemWrite}
    localparam int unsigned MEM_EN_BIT    = 1;
    localparam int unsigned MEM_WR_BIT    = 0;
    localparam int unsigned MEM_WDATA_MSB = 17;
    localparam int unsigned MEM_WDATA_LSB = 2;

    // EX_MEM_WB_signals = {reg_rd, RegWrite, MemtoReg, HLT, PCS}
    localparam int unsigned WB_RD_MSB       = 7;
    localparam int unsigned WB_RD_LSB       = 4;
    localparam int unsigned WB_REGWRITE_BIT = 3;

    localparam logic [7:0] WB_BUBBLE = 8'h00;

endpackage

// File: rtl/CPU_Register.sv
// Generic pipeline register field with load enable.
// Ports:
//   clk_i   - clock
//   rst_ni  - synchronous active-low reset, clears the field to 0
//   we_i    - load enable; field holds when low
//   d_i     - next value
//   q_o     - registered value
module CPU_Register #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (we_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_timeout_counter.sv
// Counts WAIT cycles of an outstanding memory access and flags expiry.
// Only instantiated when MEM_TIMEOUT_EN is defined.
// Ports:
//   clk_i      - clock
//   rst_ni     - synchronous active-low reset, clears the count
//   clear_i    - restart the count at 0 (takes priority over enable_i)
//   enable_i   - advance the count by one
//   expired_o  - count has reached TIMEOUT_CYCLES-1
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: consumer of the EX/MEM bundle, driver of a
// multi-cycle data memory over a req/ready handshake, and owner of the MEM/WB
// pipeline register.
// Optional feature: define MEM_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES
// cycles without mem_ready (sets sticky mem_err, retires with RegWrite=0).
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   EX_MEM_PC_next/ALU_out         - pipelined next PC, ALU result (memory address)
//   EX_MEM_MEM_signals             - {MemWriteData, MemEnable, MemWrite}
//   EX_MEM_WB_signals              - {reg_rd, RegWrite, MemtoReg, HLT, PCS}
//   mem_req/we/addr/wdata          - memory request side
//   mem_rdata/mem_ready            - memory response side
//   mem_stall                      - freeze upstream pipeline
//   MEM_WB_PC_next/ALU_out/MemData - MEM/WB register data fields
//   MEM_WB_WB_signals              - MEM/WB control bundle, 8'h00 is a bubble
//   mem_err                        - sticky timeout flag
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] EX_MEM_PC_next,
    input  logic [15:0] EX_MEM_ALU_out,
    input  logic [17:0] EX_MEM_MEM_signals,
    input  logic [7:0]  EX_MEM_WB_signals,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_stall,
    output logic [15:0] MEM_WB_PC_next,
    output logic [15:0] MEM_WB_ALU_out,
    output logic [15:0] MEM_WB_MemData,
    output logic [7:0]  MEM_WB_WB_signals,
    output logic        mem_err
);

    state_e      state_q, state_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_en, mem_wr;
    logic [15:0] wdata;
    logic        timeout;    // WAIT expired this cycle without ready
    logic        timed_out;  // current DONE follows a timeout

    assign mem_en = EX_MEM_MEM_signals[MEM_EN_BIT];
    assign mem_wr = EX_MEM_MEM_signals[MEM_WR_BIT];
    assign wdata  = EX_MEM_MEM_signals[MEM_WDATA_MSB:MEM_WDATA_LSB];

`ifdef MEM_TIMEOUT_EN
    logic cnt_expired;
    logic err_q;
    logic to_q;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   ((state_q == ST_IDLE) && mem_en && !mem_ready),
        .enable_i  (state_q == ST_WAIT),
        .expired_o (cnt_expired)
    );

    assign timeout = (state_q == ST_WAIT) && !mem_ready && cnt_expired;

    // DONE always follows the WAIT cycle directly, so a one-cycle copy of
    // the timeout strobe identifies an aborted access in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            err_q <= err_q | timeout;
            to_q  <= timeout;
        end
    end

    assign timed_out = to_q;
    assign mem_err   = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout   = 1'b0;
    assign timed_out = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        mem_req   = 1'b0;
        mem_stall = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_en) begin
                    mem_req   = 1'b1;
                    mem_stall = 1'b1;
                    if (mem_ready) begin
                        if (!mem_wr) rdata_d = mem_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_req   = 1'b1;
                mem_stall = 1'b1;
                if (mem_ready) begin
                    if (!mem_wr) rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_we    = mem_req & mem_wr;
    assign mem_addr  = mem_req ? EX_MEM_ALU_out : '0;
    assign mem_wdata = mem_req ? wdata : '0;

    // MEM/WB register: data fields hold during a stall, WB bundle bubbles.
    logic        wb_load;
    logic [15:0] memdata_d;
    logic [7:0]  wb_d;

    assign wb_load   = !mem_stall;
    assign memdata_d = ((state_q == ST_DONE) && !mem_wr) ? rdata_q : '0;

    always_comb begin
        wb_d = EX_MEM_WB_signals;
        if (mem_stall) begin
            wb_d = WB_BUBBLE;
        end else if (timed_out) begin
            wb_d[WB_REGWRITE_BIT] = 1'b0;
        end
    end

    CPU_Register #(.WIDTH(16)) u_pc_next (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .we_i   (wb_load),
        .d_i    (EX_MEM_PC_next),
        .q_o    (MEM_WB_PC_next)
    );

    CPU_Register #(.WIDTH(16)) u_alu_out (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .we_i   (wb_load),
        .d_i    (EX_MEM_ALU_out),
        .q_o    (MEM_WB_ALU_out)
    );

    CPU_Register #(.WIDTH(16)) u_mem_data (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .we_i   (wb_load),
        .d_i    (memdata_d),
        .q_o    (MEM_WB_MemData)
    );

    CPU_Register #(.WIDTH(8)) u_wb_signals (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .we_i   (1'b1),
        .d_i    (wb_d),
        .q_o    (MEM_WB_WB_signals)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: each instruction pushes its expected
// MEM/WB contents when it is driven; the entry is popped and compared when
// the instruction retires. A small responder raises mem_ready after a
// per-instruction latency. Build with MEM_TIMEOUT_EN to cover the abort path.
module tb_mem_stage_ctrl;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] alu;
        logic [15:0] md;
        logic [7:0]  wb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] ex_pc, ex_alu;
    logic [17:0] ex_mem;
    logic [7:0]  ex_wb;
    logic        mem_req, mem_we, mem_ready, mem_stall, mem_err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] wb_pc, wb_alu, wb_md;
    logic [7:0]  wb_wb;

    int   n_vec;
    int   n_err;
    exp_t sb[$];

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .EX_MEM_PC_next     (ex_pc),
        .EX_MEM_ALU_out     (ex_alu),
        .EX_MEM_MEM_signals (ex_mem),
        .EX_MEM_WB_signals  (ex_wb),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ready          (mem_ready),
        .mem_stall          (mem_stall),
        .MEM_WB_PC_next     (wb_pc),
        .MEM_WB_ALU_out     (wb_alu),
        .MEM_WB_MemData     (wb_md),
        .MEM_WB_WB_signals  (wb_wb),
        .mem_err            (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge. Drives one instruction, services the
    // memory with ready after `lat` request cycles, then checks retirement.
    task automatic run_op(input string name, input logic [15:0] pc, input logic [15:0] alu,
                          input logic [15:0] wd, input logic en, input logic wr,
                          input logic [7:0] wb, input int lat, input logic [15:0] rdata,
                          input logic [15:0] exp_md, input logic [7:0] exp_wb,
                          input int exp_stall);
        exp_t e;
        exp_t got;
        int   stalls;
        bit   done;
        ex_pc  = pc;
        ex_alu = alu;
        ex_mem = {wd, en, wr};
        ex_wb  = wb;
        e = '{pc: pc, alu: alu, md: exp_md, wb: exp_wb};
        sb.push_back(e);
        stalls = 0;
        done   = 1'b0;
        #1;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (mem_stall) begin
                if (stalls == 0) begin
                    check_eq({name, ".req"}, 32'(mem_req), 32'd1);
                    check_eq({name, ".we"}, 32'(mem_we), 32'(wr));
                    check_eq({name, ".addr"}, 32'(mem_addr), 32'(alu));
                    if (wr) check_eq({name, ".wdata"}, 32'(mem_wdata), 32'(wd));
                end
                if (stalls == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end
                stalls++;
            end else begin
                // ready/rdata outside a request must be ignored
                mem_ready = 1'b1;
                mem_rdata = 16'hDEAD;
                check_eq({name, ".req_low"}, 32'(mem_req), 32'd0);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = 16'h0000;
            if (!done) check_eq({name, ".bubble"}, 32'(wb_wb), 32'(8'h00));
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.timeout: stall still high after 64 cycles, want release", name);
        end else begin
            got = sb.pop_front();
            check_eq({name, ".pc"}, 32'(wb_pc), 32'(got.pc));
            check_eq({name, ".alu"}, 32'(wb_alu), 32'(got.alu));
            check_eq({name, ".memdata"}, 32'(wb_md), 32'(got.md));
            check_eq({name, ".wb"}, 32'(wb_wb), 32'(got.wb));
            check_eq({name, ".stalls"}, 32'(stalls), 32'(exp_stall));
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        ex_pc     = 16'h0;
        ex_alu    = 16'h0;
        ex_mem    = 18'h0;
        ex_wb     = 8'h0;
        mem_ready = 1'b0;
        mem_rdata = 16'h0;

        // Reset: two cycles low
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.pc", 32'(wb_pc), 32'd0);
        check_eq("rst.alu", 32'(wb_alu), 32'd0);
        check_eq("rst.md", 32'(wb_md), 32'd0);
        check_eq("rst.wb", 32'(wb_wb), 32'd0);
        check_eq("rst.req", 32'(mem_req), 32'd0);
        check_eq("rst.stall", 32'(mem_stall), 32'd0);
        check_eq("rst.err", 32'(mem_err), 32'd0);
        rst_n = 1'b1;

        //     name   pc       alu      wdata    en  wr  wb     lat rdata    exp_md   exp_wb stall
        run_op("add", 16'h0002, 16'h1234, 16'h0000, 0, 0, 8'h38, 0, 16'h0000, 16'h0000, 8'h38, 0);
        run_op("lw",  16'h0004, 16'h0040, 16'h0000, 1, 0, 8'h5C, 3, 16'hBEEF, 16'hBEEF, 8'h5C, 4);
        run_op("sw",  16'h0006, 16'h0042, 16'h00A5, 1, 1, 8'h00, 0, 16'h0000, 16'h0000, 8'h00, 1);
        run_op("lw0", 16'h0008, 16'h0044, 16'h0000, 1, 0, 8'h7C, 0, 16'h1357, 16'h1357, 8'h7C, 1);
        run_op("lw1", 16'h000A, 16'h0046, 16'h0000, 1, 0, 8'h9C, 1, 16'hCAFE, 16'hCAFE, 8'h9C, 2);
        run_op("sw2", 16'h000C, 16'h0048, 16'h5A5A, 1, 1, 8'h00, 2, 16'h0000, 16'h0000, 8'h00, 3);
        run_op("hlt", 16'h000E, 16'h0000, 16'h0000, 0, 0, 8'h02, 0, 16'h0000, 16'h0000, 8'h02, 0);

        // Reset while a load waits: access abandoned, no load data retired
        ex_pc  = 16'h0010;
        ex_alu = 16'h0050;
        ex_mem = {16'h0000, 1'b1, 1'b0};
        ex_wb  = 8'h5C;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("rstw.req_before", 32'(mem_req), 32'd1);
        rst_n     = 1'b0;
        ex_pc     = 16'h0;
        ex_alu    = 16'h0;
        ex_mem    = 18'h0;
        ex_wb     = 8'h0;
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        check_eq("rstw.req", 32'(mem_req), 32'd0);
        check_eq("rstw.stall", 32'(mem_stall), 32'd0);
        check_eq("rstw.md", 32'(wb_md), 32'd0);
        check_eq("rstw.wb", 32'(wb_wb), 32'd0);

        run_op("add2", 16'h0012, 16'h4321, 16'h0000, 0, 0, 8'h18, 0, 16'h0000, 16'h0000, 8'h18, 0);

`ifdef MEM_TIMEOUT_EN
        // Ready never arrives: 4 WAIT cycles, then retire with RegWrite cleared
        run_op("lwto", 16'h0014, 16'h0060, 16'h0000, 1, 0, 8'h5C, 1000, 16'h0000, 16'h0000,
               8'h54, 5);
        check_eq("to.err", 32'(mem_err), 32'd1);
        run_op("add3", 16'h0016, 16'h0777, 16'h0000, 0, 0, 8'h38, 0, 16'h0000, 16'h0000, 8'h38, 0);
        check_eq("to.err_sticky", 32'(mem_err), 32'd1);
`else
        check_eq("err.tied", 32'(mem_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
